seq_mul_param: RTL

- Parametrised sequential shift-add multiplier built around a WIDTH-bit ripple adder datapath.
- Computes a WIDTH x WIDTH product over WIDTH clock cycles, either unsigned or two's-complement signed, selected per operation.
- Uses a start/busy/done handshake.
- Serves as the general multiplier for the seq_mul area, replacing fixed 4-bit multiply logic.

---
 rtl/seq_mul_param.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seq_mul_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or signed per operation.
// Latency: WIDTH cycles in CALC after the accept edge; product/done valid after edge k+WIDTH.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
module seq_mul_param #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  // Counter width is derived from WIDTH and must not be overridden.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            nstate;

  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     count;
  logic              neg;

  logic              accept;
  logic              last_iter;
  logic [WIDTH-1:0]  addend;
  logic [WIDTH:0]    carry;
  logic [WIDTH:0]    sum;
  logic [PW-1:0]     acc_next;

  // Magnitude of an operand when it is to be read as a negative signed value.
  // -2^(WIDTH-1) maps onto 2^(WIDTH-1), which still fits the unsigned range.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    if (s && x[WIDTH-1])
      return ~x + WIDTH'(1);
    else
      return x;
  endfunction

  assign last_iter = (count == CW'(WIDTH - 1));
  assign addend    = mplier[0] ? mcand : '0;

  // Ripple-carry adder: upper accumulator half plus the gated multiplicand.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = acc[WIDTH + i] ^ addend[i] ^ carry[i];
      carry[i+1] = (acc[WIDTH + i] & addend[i]) | (carry[i] & (acc[WIDTH + i] ^ addend[i]));
    end
    sum[WIDTH] = carry[WIDTH];
  end

  // Carry-out, sum and the shifted-down lower half form the next accumulator.
  assign acc_next = {sum, acc[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nstate;
  end

  // Next-state decode and status outputs.
  always_comb begin
    nstate = state;
    accept = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nstate = CALC;
          accept = 1'b1;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter)
          nstate = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          nstate = CALC;
          accept = 1'b1;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Operand capture on accept, one shift-add step per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
    end else if (accept) begin
      mcand  <= mag(a, sgn);
      mplier <= mag(b, sgn);
      neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc    <= '0;
      count  <= '0;
    end else if (state == CALC) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      if (!last_iter)
        count <= count + CW'(1);
    end
  end

  // Result register: updated only on the edge that leaves CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      product <= '0;
    else if (state == CALC && last_iter)
      product <= neg ? (~acc_next + PW'(1)) : acc_next;
  end

endmodule
